// File: rtl/factorial_perm_engine_pkg.sv
// Shared state encodings and default widths for the factorial / permutation engine.
package factorial_perm_engine_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MULT = 3'd1;
  localparam state_t S_DONE = 3'd2;
  localparam state_t S_ERR  = 3'd3;

  localparam int N_W_DEF   = 4;
  localparam int OUT_W_DEF = 32;

endpackage

// File: rtl/factorial_perm_dp.sv
// Datapath: product register, down-counters and a full-width multiplier whose
// upper half flags overflow of the OUT_W result.
module factorial_perm_dp
  import factorial_perm_engine_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [N_W-1:0]   n,
  input  logic [N_W-1:0]   k,
  output logic [OUT_W-1:0] out,
  output logic             rem_zero,
  output logic             k_gt_n,
  output logic             ovf
);

  logic [N_W-1:0]     cnt;
  logic [N_W-1:0]     rem;
  logic [2*OUT_W-1:0] prod;

  assign prod     = (2*OUT_W)'(out) * (2*OUT_W)'(cnt);
  assign ovf      = |prod[2*OUT_W-1:OUT_W];
  assign rem_zero = (rem == '0);
  assign k_gt_n   = (k > n);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= '0;
      cnt <= '0;
      rem <= '0;
    end else if (load) begin
      out <= OUT_W'(1);
      cnt <= n;
      rem <= mode ? k : n;
    end else if (step) begin
      // rem==0 is handled before step is raised and cnt >= rem, so neither wraps
      out <= prod[OUT_W-1:0];
      cnt <= cnt - 1'b1;
      rem <= rem - 1'b1;
    end
  end

endmodule

// File: rtl/factorial_perm_engine.sv
// Iterative N! / P(N,K) engine: control FSM here, arithmetic in factorial_perm_dp.
module factorial_perm_engine
  import factorial_perm_engine_pkg::*;
#(
  parameter int N_W   = N_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             Go,
  input  logic             Mode,
  input  logic [N_W-1:0]   N,
  input  logic [N_W-1:0]   K,
  output logic [OUT_W-1:0] Out,
  output logic             Done,
  output logic             Error,
  output logic [2:0]       CS
);

  state_t state;
  state_t state_nxt;
  logic   load;
  logic   step;
  logic   rem_zero;
  logic   k_gt_n;
  logic   ovf;

  // Operands are captured even when K>N sends us straight to ERR
  assign load = (state == S_IDLE) && Go;
  assign step = (state == S_MULT) && !rem_zero && !ovf;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (Go) state_nxt = (Mode && k_gt_n) ? S_ERR : S_MULT;
      S_MULT: begin
        if (rem_zero)  state_nxt = S_DONE;
        else if (ovf)  state_nxt = S_ERR;
      end
      S_DONE: if (!Go) state_nxt = S_IDLE;
      S_ERR:  if (!Go) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  assign Done  = (state == S_DONE);
  assign Error = (state == S_ERR);
  assign CS    = state;

  factorial_perm_dp #(
    .N_W   (N_W),
    .OUT_W (OUT_W)
  ) u_dp (
    .clk      (clk),
    .rst_n    (RST),
    .load     (load),
    .step     (step),
    .mode     (Mode),
    .n        (N),
    .k        (K),
    .out      (Out),
    .rem_zero (rem_zero),
    .k_gt_n   (k_gt_n),
    .ovf      (ovf)
  );

endmodule

// File: tb/tb_factorial_perm_engine.sv
// Directed bench for factorial_perm_engine: a 32-bit instance for most scenarios
// and a 40-bit instance for the 13! result that overflows 32 bits.
module tb_factorial_perm_engine;

  logic        clk = 1'b0;
  logic        RST;
  logic        Go;
  logic        Mode;
  logic [3:0]  N;
  logic [3:0]  K;
  logic [31:0] Out;
  logic        Done;
  logic        Error;
  logic [2:0]  CS;

  logic        go40;
  logic [3:0]  n40;
  logic [39:0] out40;
  logic        done40;
  logic        err40;
  logic [2:0]  cs40;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  factorial_perm_engine #(.N_W(4), .OUT_W(32)) dut (
    .clk(clk), .RST(RST), .Go(Go), .Mode(Mode), .N(N), .K(K),
    .Out(Out), .Done(Done), .Error(Error), .CS(CS)
  );

  factorial_perm_engine #(.N_W(4), .OUT_W(40)) dut40 (
    .clk(clk), .RST(RST), .Go(go40), .Mode(1'b0), .N(n40), .K(4'd0),
    .Out(out40), .Done(done40), .Error(err40), .CS(cs40)
  );

  task automatic tick(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic m, input logic [3:0] nv, input logic [3:0] kv);
    Mode = m; N = nv; K = kv; Go = 1'b1;
  endtask

  task automatic finish_run();
    Go = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    RST = 1'b0; Go = 1'b0; Mode = 1'b0; N = 4'd0; K = 4'd0; go40 = 1'b0; n40 = 4'd0;
    tick(2);
    n_checks++; if (Out !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %0d want 0", Out); end
    n_checks++; if (CS !== 3'd0) begin n_fail++; $display("FAIL reset_cs: got %0d want 0", CS); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_checks++; if (Error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", Error); end
    RST = 1'b1;
    tick(1);
  endtask

  task automatic test_fact5();
    start(1'b0, 4'd5, 4'd0);
    tick(6);
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL f5_early_done: got %b want 0 after edge 6", Done); end
    tick(1);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL f5_done: got %b want 1", Done); end
    n_checks++; if (Out !== 32'd120) begin n_fail++; $display("FAIL f5_out: got %0d want 120", Out); end
    n_checks++; if (Error !== 1'b0) begin n_fail++; $display("FAIL f5_error: got %b want 0", Error); end
    n_checks++; if (CS !== 3'd2) begin n_fail++; $display("FAIL f5_cs: got %0d want 2", CS); end
    finish_run();
    n_checks++; if (CS !== 3'd0) begin n_fail++; $display("FAIL f5_idle_cs: got %0d want 0", CS); end
    n_checks++; if (Out !== 32'd120) begin n_fail++; $display("FAIL f5_idle_hold: got %0d want 120", Out); end
  endtask

  task automatic test_fact0();
    start(1'b0, 4'd0, 4'd0);
    tick(1);
    n_checks++; if (CS !== 3'd1) begin n_fail++; $display("FAIL f0_mult_cs: got %0d want 1", CS); end
    tick(1);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL f0_done: got %b want 1", Done); end
    n_checks++; if (Out !== 32'd1) begin n_fail++; $display("FAIL f0_out: got %0d want 1", Out); end
    finish_run();
  endtask

  task automatic test_fact12();
    start(1'b0, 4'd12, 4'd0);
    tick(13);
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL f12_early_done: got %b want 0", Done); end
    tick(1);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL f12_done: got %b want 1", Done); end
    n_checks++; if (Out !== 32'd479001600) begin n_fail++; $display("FAIL f12_out: got %0d want 479001600", Out); end
    finish_run();
  endtask

  task automatic test_overflow();
    logic [3:0] ns [2] = '{4'd13, 4'd15};
    int saw_done;
    for (int t = 0; t < 2; t++) begin
      saw_done = 0;
      start(1'b0, ns[t], 4'd0);
      for (int e = 0; e < 18; e++) begin
        tick(1);
        if (Done) saw_done++;
      end
      n_checks++; if (saw_done != 0) begin n_fail++; $display("FAIL ovf%0d_done_seen: got %0d cycles want 0", ns[t], saw_done); end
      n_checks++; if (Error !== 1'b1) begin n_fail++; $display("FAIL ovf%0d_error: got %b want 1", ns[t], Error); end
      n_checks++; if (CS !== 3'd3) begin n_fail++; $display("FAIL ovf%0d_cs: got %0d want 3", ns[t], CS); end
      finish_run();
      n_checks++; if (CS !== 3'd0) begin n_fail++; $display("FAIL ovf%0d_idle: got %0d want 0", ns[t], CS); end
    end
  endtask

  task automatic test_wide();
    n40 = 4'd13; go40 = 1'b1;
    tick(14);
    n_checks++; if (done40 !== 1'b0) begin n_fail++; $display("FAIL w13_early_done: got %b want 0", done40); end
    tick(1);
    n_checks++; if (done40 !== 1'b1) begin n_fail++; $display("FAIL w13_done: got %b want 1", done40); end
    n_checks++; if (out40 !== 40'd6227020800) begin n_fail++; $display("FAIL w13_out: got %0d want 6227020800", out40); end
    n_checks++; if (err40 !== 1'b0) begin n_fail++; $display("FAIL w13_error: got %b want 0", err40); end
    go40 = 1'b0;
    tick(1);
    n_checks++; if (cs40 !== 3'd0) begin n_fail++; $display("FAIL w13_idle: got %0d want 0", cs40); end
  endtask

  task automatic test_perm();
    start(1'b1, 4'd10, 4'd3);
    tick(4);
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL p10_3_early: got %b want 0", Done); end
    tick(1);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL p10_3_done: got %b want 1", Done); end
    n_checks++; if (Out !== 32'd720) begin n_fail++; $display("FAIL p10_3_out: got %0d want 720", Out); end
    finish_run();
    start(1'b1, 4'd4, 4'd7);
    tick(1);
    n_checks++; if (Error !== 1'b1) begin n_fail++; $display("FAIL p4_7_error: got %b want 1", Error); end
    n_checks++; if (CS !== 3'd3) begin n_fail++; $display("FAIL p4_7_cs: got %0d want 3", CS); end
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL p4_7_done: got %b want 0", Done); end
    finish_run();
  endtask

  task automatic test_reset_mid();
    start(1'b0, 4'd9, 4'd0);
    tick(3);
    RST = 1'b0; Go = 1'b0;
    tick(1);
    n_checks++; if (Out !== 32'd0) begin n_fail++; $display("FAIL mid_rst_out: got %0d want 0", Out); end
    n_checks++; if (CS !== 3'd0) begin n_fail++; $display("FAIL mid_rst_cs: got %0d want 0", CS); end
    n_checks++; if (Done !== 1'b0 || Error !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got done=%b err=%b want 0 0", Done, Error); end
    RST = 1'b1;
    start(1'b0, 4'd4, 4'd0);
    tick(6);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL mid_rst_f4_done: got %b want 1", Done); end
    n_checks++; if (Out !== 32'd24) begin n_fail++; $display("FAIL mid_rst_f4_out: got %0d want 24", Out); end
    finish_run();
  endtask

  task automatic test_back_to_back();
    start(1'b0, 4'd3, 4'd0);
    tick(5);
    n_checks++; if (Out !== 32'd6 || CS !== 3'd2) begin n_fail++; $display("FAIL held_first: got out=%0d cs=%0d want 6 2", Out, CS); end
    tick(8);
    n_checks++; if (Out !== 32'd6 || CS !== 3'd2) begin n_fail++; $display("FAIL held_stay: got out=%0d cs=%0d want 6 2", Out, CS); end
    finish_run();
    start(1'b0, 4'd5, 4'd0);
    tick(2);
    N = 4'd7; Mode = 1'b1; K = 4'd1;
    tick(5);
    n_checks++; if (Done !== 1'b1) begin n_fail++; $display("FAIL latched_done: got %b want 1", Done); end
    n_checks++; if (Out !== 32'd120) begin n_fail++; $display("FAIL latched_out: got %0d want 120", Out); end
    finish_run();
  endtask

  initial begin
    test_reset();
    test_fact5();
    test_fact0();
    test_fact12();
    test_overflow();
    test_wide();
    test_perm();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
